// File: rtl/low_mem_arbiter_pkg.sv
// low_mem_arbiter_pkg
//   Shared definitions for the lower-level memory arbiter: the grant state
//   encoding, the owner encoding used by the round-robin pointer, and the
//   ceiling-log2 helper that sizes the block-address field.
// Ports: none (package).
package low_mem_arbiter_pkg;

  // Grant state: nobody, the I-cache, or the D-cache owns the memory port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_e;

  // Encoding of the priority pointer: which cache completed most recently.
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // Ceiling log2, used for parameter arithmetic only.
  function automatic int log2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/low_mem_arbiter.sv
// low_mem_arbiter
//   Shares the single lower-level memory port between the I-cache and the
//   D-cache. One block transaction is granted at a time and held until the
//   memory pulses Rdy_Low; under contention the grant alternates between the
//   two caches with no idle cycle in between.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   Req_I, A_I          I-cache read request and block address
//   Rdy_I, DO_I         I-cache completion strobe and fill data
//   Req_D, Wr_D, A_D    D-cache request, write-back flag, block address
//   DI_D                D-cache write-back data
//   Rdy_D, DO_D         D-cache completion strobe and fill data
//   Req_Low, Wr_Low     request / write flag to the lower level
//   A_Low, DO_Low       address / write data to the lower level
//   DI_Low, Rdy_Low     read data / completion pulse from the lower level
//   Err                 sticky protocol-error flag
module low_mem_arbiter
  import low_mem_arbiter_pkg::*;
#(
  parameter int BLOCK_SIZE  = 8,
  parameter int BLOCK_WIDTH = BLOCK_SIZE * 32,
  parameter int LOW_SIZE    = 2 + log2(BLOCK_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Req_I,
  input  logic [31:LOW_SIZE]     A_I,
  output logic                   Rdy_I,
  output logic [BLOCK_WIDTH-1:0] DO_I,
  input  logic                   Req_D,
  input  logic                   Wr_D,
  input  logic [31:LOW_SIZE]     A_D,
  input  logic [BLOCK_WIDTH-1:0] DI_D,
  output logic                   Rdy_D,
  output logic [BLOCK_WIDTH-1:0] DO_D,
  output logic                   Req_Low,
  output logic                   Wr_Low,
  output logic [31:LOW_SIZE]     A_Low,
  output logic [BLOCK_WIDTH-1:0] DO_Low,
  input  logic [BLOCK_WIDTH-1:0] DI_Low,
  input  logic                   Rdy_Low,
  output logic                   Err
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic       err_q, err_d;

  // State register. The pointer resets to D so that the I-cache wins the
  // first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= OWNER_D;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. A grant is held until Rdy_Low regardless of the
  // owner's request; an owner dropping its request early is flagged but is
  // not treated as an abort. On completion the owner's own request is
  // ignored, so a waiting peer is served next without a bubble.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (Rdy_Low) begin
          err_d = 1'b1;
        end
        if (Req_I && Req_D) begin
          state_d = (last_q == OWNER_I) ? ST_GNT_D : ST_GNT_I;
        end else if (Req_I) begin
          state_d = ST_GNT_I;
        end else if (Req_D) begin
          state_d = ST_GNT_D;
        end
      end
      ST_GNT_I: begin
        if (Rdy_Low) begin
          last_d  = OWNER_I;
          state_d = Req_D ? ST_GNT_D : ST_IDLE;
        end else if (!Req_I) begin
          err_d = 1'b1;
        end
      end
      ST_GNT_D: begin
        if (Rdy_Low) begin
          last_d  = OWNER_D;
          state_d = Req_I ? ST_GNT_I : ST_IDLE;
        end else if (!Req_D) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output muxing. The I-cache only ever reads, so its grant drives a zero
  // write flag and zero write data.
  always_comb begin
    Req_Low = 1'b0;
    Wr_Low  = 1'b0;
    A_Low   = '0;
    DO_Low  = '0;
    Rdy_I   = 1'b0;
    Rdy_D   = 1'b0;
    case (state_q)
      ST_GNT_I: begin
        Req_Low = 1'b1;
        A_Low   = A_I;
        Rdy_I   = Rdy_Low;
      end
      ST_GNT_D: begin
        Req_Low = 1'b1;
        Wr_Low  = Wr_D;
        A_Low   = A_D;
        DO_Low  = DI_D;
        Rdy_D   = Rdy_Low;
      end
      default: begin
      end
    endcase
  end

  // Fill data is broadcast to both caches; only the Rdy strobe marks it valid.
  assign DO_I = DI_Low;
  assign DO_D = DI_Low;
  assign Err  = err_q;

endmodule
